// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: blank pattern,
// decimal-point bit position, active-low hex glyph table and a clog2 helper.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         DP_BIT    = 0;

    // Segment order {A,B,C,D,E,F,G,DP}, active low, DP off
    localparam logic [7:0] GLYPHS [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble-to-glyph decoder; dp lights the decimal point.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] glyph
);

    always_comb begin
        glyph = GLYPHS[nibble];
        if (dp) glyph[DP_BIT] = 1'b0;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous snapshot,
// leading-zero suppression, blank/DP masks, PWM brightness and dead time.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int REFRESH_MAX = 99999,
    parameter int DUTY_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lz_suppress,
    input  logic [DUTY_W-1:0]     bright,
    output logic [DIGITS-1:0]     led_en,
    output logic [7:0]            led_cx,
    output logic                  frame_done
);

    localparam int CNT_W = clog2(REFRESH_MAX + 1);
    localparam int IDX_W = clog2(DIGITS);
    localparam int ON_W  = DUTY_W + clog2(REFRESH_MAX + 2);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_MAX);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*DIGITS-1:0]     data_snap;
    logic [DIGITS-1:0]       dp_snap;
    logic [DIGITS-1:0]       blank_snap;
    logic                    lz_snap;
    logic [DUTY_W-1:0]       bright_snap;

    logic                    last_cycle;
    logic [ON_W-1:0]         on_len;
    logic [DIGITS-1:0]       suppressed;
    logic                    nonzero_seen;
    logic [3:0]              nibble;
    logic [7:0]              glyph;
    logic [DIGITS-1:0]       digit_sel;
    logic                    lit;

    assign last_cycle = (idx == IDX_LAST) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Snapshot follows the inputs while disabled and reloads only at frame end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_snap   <= '0;
            dp_snap     <= '0;
            blank_snap  <= '0;
            lz_snap     <= 1'b0;
            bright_snap <= '0;
        end else if (!en || last_cycle) begin
            data_snap   <= data;
            dp_snap     <= dp_mask;
            blank_snap  <= blank_mask;
            lz_snap     <= lz_suppress;
            bright_snap <= bright;
        end
    end

    always_comb begin
        nonzero_seen = 1'b0;
        suppressed   = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            nonzero_seen  = nonzero_seen | (data_snap[4*k +: 4] != 4'h0);
            suppressed[k] = lz_snap & ~nonzero_seen;
        end
    end

    always_comb begin
        on_len    = ((ON_W'(bright_snap) + ON_W'(1)) * ON_W'(REFRESH_MAX + 1)) >> DUTY_W;
        nibble    = data_snap[4*int'(idx) +: 4];
        digit_sel = DIGITS'(1) << idx;
        lit       = en && (cnt != '0) && (ON_W'(cnt) < on_len)
                    && !blank_snap[idx] && !suppressed[idx];
    end

    seg_hex_decoder u_dec (
        .nibble (nibble),
        .dp     (dp_snap[idx]),
        .glyph  (glyph)
    );

    // Output register stage: pins lag the cnt/idx state by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_en     <= '1;
            led_cx     <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            frame_done <= en && last_cycle;
            if (lit) begin
                led_en <= ~digit_sel;
                led_cx <= glyph;
            end else begin
                led_en <= '1;
                led_cx <= SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized and directed bench for seg_scan_ctrl against a frame-position model.
module tb_seg_scan_ctrl;

    localparam int DIGITS      = 4;
    localparam int REFRESH_MAX = 15;
    localparam int DUTY_W      = 2;
    localparam int SLOT        = REFRESH_MAX + 1;
    localparam int FRAME       = SLOT * DIGITS;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] data;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic        lz_suppress;
    logic [1:0]  bright;
    logic [3:0]  led_en;
    logic [7:0]  led_cx;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] gl [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                            8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    // Model: position within the frame plus the captured display settings
    int          pos;
    logic [15:0] s_data;
    logic [3:0]  s_dp, s_blank;
    logic        s_lz;
    logic [1:0]  s_bright;

    seg_scan_ctrl #(
        .DIGITS      (DIGITS),
        .REFRESH_MAX (REFRESH_MAX),
        .DUTY_W      (DUTY_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .data        (data),
        .dp_mask     (dp_mask),
        .blank_mask  (blank_mask),
        .lz_suppress (lz_suppress),
        .bright      (bright),
        .led_en      (led_en),
        .led_cx      (led_cx),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        int digit, c, on_len, hn;
        logic lit;
        logic [3:0] nib, e_en;
        logic [7:0] e_cx;
        logic e_fd;
        @(posedge clk);
        digit  = pos / SLOT;
        c      = pos % SLOT;
        on_len = ((int'(s_bright) + 1) * SLOT) / (1 << DUTY_W);
        hn = 0;
        for (int k = 0; k < DIGITS; k++) if (s_data[4*k +: 4] != 4'h0) hn = k;
        nib  = s_data[4*digit +: 4];
        lit  = !rst && en && c >= 1 && c < on_len && !s_blank[digit] && !(s_lz && digit > hn);
        e_en = lit ? ~(4'b0001 << digit) : 4'hF;
        e_cx = lit ? (gl[nib] & (s_dp[digit] ? 8'hFE : 8'hFF)) : 8'hFF;
        e_fd = !rst && en && pos == FRAME - 1;
        if (rst) begin
            pos = 0;
            {s_data, s_dp, s_blank, s_lz, s_bright} = '0;
        end else if (!en || pos == FRAME - 1) begin
            {s_data, s_dp, s_blank, s_lz, s_bright} = {data, dp_mask, blank_mask, lz_suppress, bright};
            pos = en ? 0 : 0;
        end else begin
            pos = pos + 1;
        end
        #1;
        check("led_en", 32'(led_en), 32'(e_en));
        check("led_cx", 32'(led_cx), 32'(e_cx));
        check("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_done !== 1'b1 && n < 3 * FRAME);
        if (frame_done !== 1'b1) check("fd_wait", 32'(frame_done), 32'd1);
    endtask

    initial begin
        int n, lit_cnt;
        rst = 1'b1; en = 1'b1; data = 16'h1234; dp_mask = '0; blank_mask = '0;
        lz_suppress = 1'b0; bright = 2'd3;
        pos = 0;
        {s_data, s_dp, s_blank, s_lz, s_bright} = '0;
        #1;
        check("rst_led_en", 32'(led_en), 32'hF);
        check("rst_led_cx", 32'(led_cx), 32'hFF);
        check("rst_fd", 32'(frame_done), 32'h0);
        ticks(2);
        rst = 1'b0;

        // Reset snapshot frame, then 1234 at full brightness
        wait_fd(n);
        wait_fd(n);
        check("frame_period", 32'(n), 32'(FRAME));
        ticks(FRAME);

        // Minimum brightness: three lit cycles per digit slot
        bright = 2'd0;
        wait_fd(n);
        lit_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (led_en != 4'hF) lit_cnt++;
        end
        check("lit_cycles_b0", 32'(lit_cnt), 32'(3 * DIGITS));

        // Mid-frame data change waits for the next frame
        bright = 2'd3;
        ticks(20);
        data = 16'hFFFF;
        wait_fd(n);
        n = 0;
        do begin tick(); n++; end while (led_en == 4'hF && n < 2 * SLOT);
        check("ffff_glyph", 32'(led_cx), 32'h71);
        ticks(FRAME);

        // Leading-zero suppression with decimal point
        lz_suppress = 1'b1; data = 16'h0050; dp_mask = 4'b0010;
        ticks(2 * FRAME);
        data = 16'h0000;
        ticks(2 * FRAME);

        // Blank mask on digit 2
        lz_suppress = 1'b0; data = 16'h8A3C; dp_mask = 4'b1111; blank_mask = 4'b0100;
        ticks(2 * FRAME);

        // Enable drop mid slot 2, restart, then asynchronous reset mid-frame
        n = 0;
        while (pos != 2 * SLOT + 5 && n < 2 * FRAME) begin tick(); n++; end
        en = 1'b0;
        ticks(5);
        data = 16'h4321; blank_mask = '0; dp_mask = 4'b0001;
        ticks(3);
        en = 1'b1;
        ticks(FRAME + 30);
        #2 rst = 1'b1;
        #1;
        check("async_rst_led_en", 32'(led_en), 32'hF);
        check("async_rst_led_cx", 32'(led_cx), 32'hFF);
        check("async_rst_fd", 32'(frame_done), 32'h0);
        ticks(2);
        rst = 1'b0;
        ticks(FRAME);

        // Randomized inputs, occasional enable toggles
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 19) == 0) data = 16'($urandom);
            if ($urandom_range(0, 29) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 29) == 0) blank_mask = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
            if ($urandom_range(0, 39) == 0) lz_suppress = 1'($urandom);
            if ($urandom_range(0, 29) == 0) bright = 2'($urandom);
            if ($urandom_range(0, 15) == 0) data[15:8] = 8'h00;
            if ($urandom_range(0, 199) == 0) en = ~en;
            if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
